// File: rtl/acc_counter_pkg.sv
// ============================================================================
// Module   : acc_counter_pkg
// Brief    : Shared types for the access counter bank (FSM states, port names)
// Revision : 1.0
// ============================================================================
`default_nettype none

package acc_counter_pkg;

  localparam int unsigned DEFAULT_NB_PORTS = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2
  } acc_state_e;

  // Energy categories in dump order: off-chip, on-chip write, on-chip read.
  typedef enum logic [3:0] {
    PORT_ACT_IN_OFFCHIP  = 4'd0,
    PORT_ACT_OUT_OFFCHIP = 4'd1,
    PORT_WEIGHTS_OFFCHIP = 4'd2,
    PORT_ACT_IN_WR       = 4'd3,
    PORT_ACT_OUT_WR      = 4'd4,
    PORT_WEIGHTS_WR      = 4'd5,
    PORT_FIFO_WR         = 4'd6,
    PORT_ACT_IN_RD       = 4'd7,
    PORT_ACT_OUT_RD      = 4'd8,
    PORT_WEIGHTS_RD      = 4'd9,
    PORT_FIFO_RD         = 4'd10
  } acc_port_e;

endpackage

`default_nettype wire

// File: rtl/saturating_accumulator.sv
// ============================================================================
// Module   : saturating_accumulator
// Brief    : One saturating event counter with a sticky overflow flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module saturating_accumulator #(
  parameter int COUNT_WIDTH    = 32,
  parameter int WORD_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      clear,
  input  logic                      inc_en,
  input  logic [WORD_CNT_WIDTH-1:0] inc_words,
  output logic [COUNT_WIDTH-1:0]    count,
  output logic                      overflow
);

  localparam int SUM_W = COUNT_WIDTH + 1;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [SUM_W-1:0]       sum;

  always_comb begin
    sum        = {1'b0, count_q} + SUM_W'(inc_words);
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (inc_en) begin
      // Carry out of the widened sum means the true total no longer fits.
      if (sum[COUNT_WIDTH]) begin
        count_d    = '1;
        overflow_d = 1'b1;
      end else begin
        count_d = sum[COUNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: rtl/access_counter_bank.sv
// ============================================================================
// Module   : access_counter_bank
// Brief    : Per-port saturating access counters with snapshot-and-dump readout
// Revision : 1.0
// ============================================================================
`default_nettype none

module access_counter_bank
  import acc_counter_pkg::*;
#(
  parameter int NB_PORTS       = DEFAULT_NB_PORTS,
  parameter int COUNT_WIDTH    = 32,
  parameter int WORD_CNT_WIDTH = 4,
  localparam int PORT_W        = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_in,
  input  logic                               enable,
  input  logic                               clear,
  input  logic [NB_PORTS-1:0]                access_strobe,
  input  logic [NB_PORTS*WORD_CNT_WIDTH-1:0] access_words,
  input  logic                               snapshot_req,
  output logic                               busy,
  output logic                               dump_valid,
  input  logic                               dump_ready,
  output logic [PORT_W-1:0]                  dump_port,
  output logic [COUNT_WIDTH-1:0]             dump_count,
  output logic                               dump_last,
  output logic [NB_PORTS-1:0]                overflow
);

  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NB_PORTS - 1);

  logic [COUNT_WIDTH-1:0] live_count [NB_PORTS];
  logic [COUNT_WIDTH-1:0] shadow_q   [NB_PORTS];
  logic [COUNT_WIDTH-1:0] shadow_d   [NB_PORTS];

  acc_state_e             state_q, state_d;
  logic [PORT_W-1:0]      port_q, port_d, port_nxt;
  logic [COUNT_WIDTH-1:0] dump_count_q, dump_count_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;

  generate
    for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
      saturating_accumulator #(
        .COUNT_WIDTH    (COUNT_WIDTH),
        .WORD_CNT_WIDTH (WORD_CNT_WIDTH)
      ) u_acc (
        .clk       (clk),
        .rst_in    (rst_in),
        .clear     (clear),
        .inc_en    (enable & access_strobe[p]),
        .inc_words (access_words[p*WORD_CNT_WIDTH +: WORD_CNT_WIDTH]),
        .count     (live_count[p]),
        .overflow  (overflow[p])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    dump_count_d = dump_count_q;
    valid_d      = valid_q;
    last_d       = last_q;
    busy_d       = busy_q;
    shadow_d     = shadow_q;
    port_nxt     = port_q + PORT_W'(1);

    case (state_q)
      IDLE: begin
        if (snapshot_req) begin
          // Sampling the live registers on the accepting edge keeps a
          // same-cycle clear or increment out of the snapshot.
          state_d  = CAPTURE;
          busy_d   = 1'b1;
          shadow_d = live_count;
        end
      end
      CAPTURE: begin
        state_d      = DUMP;
        valid_d      = 1'b1;
        port_d       = '0;
        dump_count_d = shadow_q[0];
        last_d       = (NB_PORTS == 1);
      end
      DUMP: begin
        if (dump_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            port_d  = '0;
          end else begin
            port_d       = port_nxt;
            dump_count_d = shadow_q[port_nxt];
            last_d       = (port_nxt == LAST_PORT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= IDLE;
      port_q       <= '0;
      dump_count_q <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NB_PORTS; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      dump_count_q <= dump_count_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      shadow_q     <= shadow_d;
    end
  end

  assign busy       = busy_q;
  assign dump_valid = valid_q;
  assign dump_port  = port_q;
  assign dump_count = dump_count_q;
  assign dump_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_access_counter_bank.sv
// ============================================================================
// Module   : tb_access_counter_bank
// Brief    : Directed scoreboard bench for access_counter_bank (8-bit counters)
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_access_counter_bank;

  localparam int NB = 11;
  localparam int CW = 8;
  localparam int WW = 4;
  localparam int PW = $clog2(NB);
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_in, enable, clear, snapshot_req, dump_ready;
  logic [NB-1:0]     access_strobe;
  logic [NB*WW-1:0]  access_words;
  logic              busy, dump_valid, dump_last;
  logic [PW-1:0]     dump_port;
  logic [CW-1:0]     dump_count;
  logic [NB-1:0]     overflow;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [CW-1:0] count;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned model_cnt [NB];
  logic [NB-1:0] model_ovf;
  int checks = 0;
  int errors = 0;

  access_counter_bank #(
    .NB_PORTS       (NB),
    .COUNT_WIDTH    (CW),
    .WORD_CNT_WIDTH (WW)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .enable        (enable),
    .clear         (clear),
    .access_strobe (access_strobe),
    .access_words  (access_words),
    .snapshot_req  (snapshot_req),
    .busy          (busy),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_port     (dump_port),
    .dump_count    (dump_count),
    .dump_last     (dump_last),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model applies exactly what the DUT samples there.
  task automatic tick();
    int unsigned s;
    @(posedge clk);
    if (rst_in || clear) begin
      for (int p = 0; p < NB; p++) model_cnt[p] = 0;
      model_ovf = '0;
    end else if (enable) begin
      for (int p = 0; p < NB; p++) begin
        if (access_strobe[p]) begin
          s = model_cnt[p] + int'(access_words[p*WW +: WW]);
          if (s > MAXC) begin
            model_cnt[p] = MAXC;
            model_ovf[p] = 1'b1;
          end else begin
            model_cnt[p] = s;
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_words(input int w);
    for (int p = 0; p < NB; p++) access_words[p*WW +: WW] = WW'(w);
  endtask

  task automatic snapshot(input string tag, input logic clr);
    beat_t b;
    snapshot_req  = 1'b1;
    clear         = clr;
    access_strobe = '0;
    for (int p = 0; p < NB; p++) begin
      b.port  = PW'(p);
      b.count = CW'(model_cnt[p]);
      b.last  = (p == NB - 1);
      exp_q.push_back(b);
    end
    tick();
    snapshot_req = 1'b0;
    clear        = 1'b0;
    chk($sformatf("%s busy_capture", tag), busy, 1);
    chk($sformatf("%s valid_capture", tag), dump_valid, 0);
    tick();
    chk($sformatf("%s first_valid", tag), dump_valid, 1);
    chk($sformatf("%s first_port", tag), dump_port, 0);
  endtask

  task automatic drain(input string tag, input int stall_beat, input int stall_cycles);
    int    hs = 0;
    int    guard = 0;
    int    stalled = 0;
    beat_t held, b;
    while (hs < NB && guard < 100) begin
      dump_ready = !(hs == stall_beat && stalled < stall_cycles);
      @(negedge clk);
      if (dump_valid && !dump_ready) begin
        if (stalled == 0) held = {dump_port, dump_count, dump_last};
        else chk($sformatf("%s hold_beat%0d", tag, hs), {dump_port, dump_count, dump_last}, held);
        stalled++;
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s extra_beat", tag), 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk($sformatf("%s port_beat%0d", tag, hs), dump_port, b.port);
          chk($sformatf("%s count_beat%0d", tag, hs), dump_count, b.count);
          chk($sformatf("%s last_beat%0d", tag, hs), dump_last, b.last);
        end
        hs++;
      end
      tick();
      guard++;
    end
    dump_ready = 1'b0;
    chk($sformatf("%s handshakes", tag), hs, NB);
    chk($sformatf("%s valid_after", tag), dump_valid, 0);
    chk($sformatf("%s busy_after", tag), busy, 0);
  endtask

  initial begin
    rst_in = 1'b1; enable = 1'b0; clear = 1'b0; snapshot_req = 1'b0;
    dump_ready = 1'b0; access_strobe = '0; access_words = '0;
    model_ovf = '0;
    for (int p = 0; p < NB; p++) model_cnt[p] = 0;
    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset valid", dump_valid, 0);
    chk("reset last", dump_last, 0);
    chk("reset port", dump_port, 0);
    chk("reset overflow", overflow, 0);
    rst_in = 1'b0;
    tick();

    // Strobes with enable low must not count.
    enable = 1'b0; access_strobe = '1; set_words(5);
    repeat (10) tick();
    snapshot("disabled", 1'b0);
    drain("disabled", -1, 0);

    // Single-port accumulation.
    enable = 1'b1; access_strobe = NB'(1 << 2); set_words(3);
    repeat (5) tick();
    snapshot("port2", 1'b0);
    drain("port2", -1, 0);

    // Mixed ports with distinct word counts and a disabled cycle; stall beat 4.
    access_strobe = 11'b101_1010_0101;
    for (int p = 0; p < NB; p++) access_words[p*WW +: WW] = WW'(p + 1);
    repeat (2) tick();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    snapshot("mixed", 1'b0);
    drain("mixed", 4, 3);

    // Clear together with snapshot keeps pre-clear values; count during dump.
    clear = 1'b1; tick(); clear = 1'b0;
    access_strobe = NB'(1 << 1); set_words(7); tick();
    snapshot("snapclr", 1'b1);
    access_strobe = NB'(1 << 3); set_words(1);
    drain("snapclr", -1, 0);
    access_strobe = '0;
    snapshot("after_clr", 1'b0);
    drain("after_clr", -1, 0);

    // Reset in the middle of a dump.
    access_strobe = '1; set_words(2); tick();
    snapshot("midrst", 1'b0);
    dump_ready = 1'b1;
    repeat (5) tick();
    chk("midrst port5", dump_port, 5);
    rst_in = 1'b1; dump_ready = 1'b0;
    tick();
    rst_in = 1'b0;
    chk("midrst valid", dump_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst last", dump_last, 0);
    exp_q.delete();
    snapshot("postrst", 1'b0);
    drain("postrst", -1, 0);

    // Saturation on port 0: 200 words then 100 more.
    access_strobe = NB'(1); set_words(10);
    repeat (20) tick();
    chk("sat no_ovf_at_200", overflow, model_ovf);
    repeat (10) tick();
    chk("sat ovf_set", overflow, model_ovf);
    chk("sat ovf_bit0", overflow[0], 1);
    snapshot("sat", 1'b0);
    drain("sat", -1, 0);
    chk("sat ovf_sticky", overflow[0], 1);
    // Clear wins over a same-cycle increment.
    access_strobe = NB'(1); clear = 1'b1; tick(); clear = 1'b0;
    access_strobe = '0;
    chk("clr ovf", overflow, 0);
    snapshot("clr", 1'b0);
    drain("clr", -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
